ysyx_22040237_wbu: RTL and testbench
====================================

Name: ysyx_22040237_wbu

Overview:
- Writeback/commit unit of the single-cycle core; consumes the execute unit's result (rd_data, pc_jump_addr) and architectural side effects.
- Owns the 32-entry GPR file, the PC register and a retired-instruction counter.
- Owns the run/halt state machine, which replaces per-unit simulation-stop calls with a single registered halt status.
- Provides two combinational GPR read ports to decode.

Parameters:
- XLEN, 64, datapath width of GPRs, PC and counter.
- RESET_PC, 64'h8000_0000, PC value after reset.
- PC_STEP, 4, PC increment for non-jump commits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low (rst==0 at posedge resets).
- commit_valid  input  1  current instruction completes this cycle.
- rd_wen  input  1  instruction writes rd.
- rd_addr  input  5  destination register index.
- rd_data  input  XLEN  result from execute.
- jump_en  input  1  take pc_jump_addr instead of pc+PC_STEP.
- pc_jump_addr  input  XLEN  jump/branch target from execute.
- inst_ebreak  input  1  committing instruction is ebreak.
- invalid_inst  input  1  committing instruction failed decode.
- rs1_addr  input  5  read port 1 index.
- rs2_addr  input  5  read port 2 index.
- rs1_data  output  XLEN  GPR[rs1_addr], combinational.
- rs2_data  output  XLEN  GPR[rs2_addr], combinational.
- pc  output  XLEN  current PC, registered.
- halted  output  1  core is in HALT, registered.
- halt_abort  output  1  halt cause was invalid_inst, registered.
- halt_code  output  XLEN  GPR[10] (a0) captured at halt, registered.
- retired  output  XLEN  count of committed instructions, registered.

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC; GPR[1..31]=0; halted=0; halt_abort=0; halt_code=0; retired=0; state=RUN.
  - Applies in any state, including mid-HALT and with commit_valid=1; reset wins over all commits.
- States: RUN, HALT (encoded by halted).
- A commit occurs at a posedge with rst==1, state==RUN and commit_valid==1.
- Commit in RUN, no halt cause:
  - If rd_wen and rd_addr!=0, GPR[rd_addr] <= rd_data.
  - pc <= jump_en ? pc_jump_addr : pc+PC_STEP. Addition is modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  - retired <= retired+1, modulo 2^XLEN.
- Commit with inst_ebreak=1:
  - GPR write suppressed; pc unchanged; retired increments.
  - halt_code <= GPR[10] value before the edge; halted <= 1; halt_abort <= 0.
- Commit with invalid_inst=1:
  - GPR write suppressed; pc unchanged (remains the faulting PC); retired unchanged.
  - halted <= 1; halt_abort <= 1; halt_code <= all-ones (-1).
- inst_ebreak and invalid_inst both set: invalid_inst has priority and abort semantics apply.
- inst_ebreak or invalid_inst with commit_valid=0: ignored.
- HALT:
  - All commit inputs ignored; GPRs, pc, retired and halt_* are frozen.
  - Only reset leaves HALT.
- GPR[0] always reads 0. Writes to x0 are discarded but still count as a commit (pc and retired advance).
- Read ports:
  - Pure combinational from the register array, with no write bypass. A read of the index being written this cycle returns the old value; the new value is visible after the edge.
  - Both ports may read the same index.
- Latency: a commit's effects are visible on all outputs one cycle after the committing edge.
- No X propagation: inputs are don't-care when commit_valid==0 or in HALT.

Test Plan:
- Reset, then idle with commit_valid=0 for 3 cycles -> pc=0x8000_0000, retired=0, halted=0, rs1_data=rs2_data=0 for all indices.
- Commit rd_wen=1, rd_addr=5, rd_data=0x1234, jump_en=0 -> next cycle GPR[5]=0x1234 on rs1, pc=0x8000_0004, retired=1. Same-cycle read of x5 before the edge returns 0.
- Commit rd_addr=0, rd_data=0xDEAD, jump_en=1, pc_jump_addr=0x8000_0100 -> x0 reads 0, pc=0x8000_0100, retired incremented.
- Write a0=0x2A, then commit inst_ebreak=1 -> halted=1, halt_abort=0, halt_code=0x2A, pc frozen. Further commits with rd_wen=1 change nothing.
- Commit with invalid_inst=1 and inst_ebreak=1 at pc=0x8000_0008 -> halted=1, halt_abort=1, halt_code=64'hFFFF_FFFF_FFFF_FFFF, pc=0x8000_0008, retired unchanged.
- While halted, or concurrently with a commit, drive rst=0 for one edge -> all outputs back to reset values. Force pc=0xFFFF_FFFF_FFFF_FFFC via a jump, then commit a non-jump -> pc=0.

Source files
------------

// File: rtl/ysyx_22040237_wbu.sv
// Writeback/commit unit: GPR file, PC, retired counter and RUN/HALT control.
// Latency: commit effects visible one cycle after the committing edge; reads are combinational.
// Backpressure: none; a commit is always accepted in RUN and ignored in HALT.
//
// Ports:
//   clk, rst            clock and synchronous active-low reset
//   commit_valid        instruction completes this cycle
//   rd_wen/addr/data    GPR write request from execute
//   jump_en/pc_jump_addr  next-PC selection
//   inst_ebreak         clean halt, a0 captured as halt_code
//   invalid_inst        abort halt, halt_code forced to -1
//   rs1/rs2_addr/data   combinational GPR read ports for decode
//   pc, halted, halt_abort, halt_code, retired  registered status
module ysyx_22040237_wbu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic            rd_wen,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            jump_en,
  input  logic [XLEN-1:0] pc_jump_addr,
  input  logic            inst_ebreak,
  input  logic            invalid_inst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic            halt_abort,
  output logic [XLEN-1:0] halt_code,
  output logic [XLEN-1:0] retired
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ONE  = XLEN'(1);

  state_t          state;
  logic [XLEN-1:0] gpr [0:31];

  // Entry 0 is reset to zero and never written, but the explicit mux keeps
  // x0 reading zero independent of array contents.
  assign rs1_data = (rs1_addr == 5'd0) ? '0 : gpr[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : gpr[rs2_addr];

  assign halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      halt_abort <= 1'b0;
      halt_code  <= '0;
      retired    <= '0;
      for (int i = 0; i < 32; i++) begin
        gpr[i] <= '0;
      end
    end else if (state == RUN && commit_valid) begin
      if (invalid_inst) begin
        // Abort wins over ebreak: pc stays on the faulting instruction and
        // the instruction is not counted as retired.
        state      <= HALT;
        halt_abort <= 1'b1;
        halt_code  <= '1;
      end else if (inst_ebreak) begin
        // a0 is sampled before the edge; the GPR write is suppressed anyway.
        state      <= HALT;
        halt_abort <= 1'b0;
        halt_code  <= gpr[10];
        retired    <= retired + ONE;
      end else begin
        if (rd_wen && rd_addr != 5'd0) begin
          gpr[rd_addr] <= rd_data;
        end
        pc      <= jump_en ? pc_jump_addr : pc + STEP;
        retired <= retired + ONE;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_wbu.sv
module tb_ysyx_22040237_wbu;

  logic        clk;
  logic        rst;
  logic        commit_valid;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        jump_en;
  logic [63:0] pc_jump_addr;
  logic        inst_ebreak;
  logic        invalid_inst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] pc;
  logic        halted;
  logic        halt_abort;
  logic [63:0] halt_code;
  logic [63:0] retired;

  int checks = 0;
  int errors = 0;

  ysyx_22040237_wbu dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .rd_wen       (rd_wen),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .jump_en      (jump_en),
    .pc_jump_addr (pc_jump_addr),
    .inst_ebreak  (inst_ebreak),
    .invalid_inst (invalid_inst),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .pc           (pc),
    .halted       (halted),
    .halt_abort   (halt_abort),
    .halt_code    (halt_code),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs changed after this return are stable for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    commit_valid = 1'b0;
    rd_wen       = 1'b0;
    rd_addr      = 5'd0;
    rd_data      = '0;
    jump_en      = 1'b0;
    pc_jump_addr = '0;
    inst_ebreak  = 1'b0;
    invalid_inst = 1'b0;
  endtask

  task automatic commit(input logic wen, input logic [4:0] addr, input logic [63:0] data,
                        input logic jen, input logic [63:0] jaddr,
                        input logic ebrk, input logic inv);
    commit_valid = 1'b1;
    rd_wen       = wen;
    rd_addr      = addr;
    rd_data      = data;
    jump_en      = jen;
    pc_jump_addr = jaddr;
    inst_ebreak  = ebrk;
    invalid_inst = inv;
    tick();
    idle();
  endtask

  task automatic rd1(input logic [4:0] a, input string tag, input logic [63:0] exp);
    rs1_addr = a;
    #1;
    chk(tag, rs1_data, exp);
  endtask

  task automatic rd2(input logic [4:0] a, input string tag, input logic [63:0] exp);
    rs2_addr = a;
    #1;
    chk(tag, rs2_data, exp);
  endtask

  initial begin
    idle();
    rst      = 1'b0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    tick();
    tick();
    rst = 1'b1;

    // Reset state and three idle cycles
    chk("rst_pc", pc, 64'h8000_0000);
    chk("rst_retired", retired, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_abort", {63'd0, halt_abort}, 64'd0);
    chk("rst_code", halt_code, 64'd0);
    tick(); tick(); tick();
    chk("idle_pc", pc, 64'h8000_0000);
    chk("idle_retired", retired, 64'd0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk("idle_rs1", rs1_data, 64'd0);
      chk("idle_rs2", rs2_data, 64'd0);
    end

    // x5 write: old value visible until the edge, then new value
    rs1_addr     = 5'd5;
    commit_valid = 1'b1;
    rd_wen       = 1'b1;
    rd_addr      = 5'd5;
    rd_data      = 64'h1234;
    #1;
    chk("x5_pre_edge", rs1_data, 64'd0);
    tick();
    idle();
    chk("x5_post", rs1_data, 64'h1234);
    chk("x5_pc", pc, 64'h8000_0004);
    chk("x5_retired", retired, 64'd1);
    rd2(5'd5, "x5_both_ports", 64'h1234);

    // x0 write discarded, jump taken, still retires
    commit(1'b1, 5'd0, 64'hDEAD, 1'b1, 64'h8000_0100, 1'b0, 1'b0);
    rd1(5'd0, "x0_zero", 64'd0);
    chk("x0_pc", pc, 64'h8000_0100);
    chk("x0_retired", retired, 64'd2);

    // a0 = 0x2A
    commit(1'b1, 5'd10, 64'h2A, 1'b0, 64'd0, 1'b0, 1'b0);
    rd2(5'd10, "a0_write", 64'h2A);
    chk("a0_pc", pc, 64'h8000_0104);
    chk("a0_retired", retired, 64'd3);

    // ebreak with a suppressed write to a0
    commit(1'b1, 5'd10, 64'h55, 1'b1, 64'h1000, 1'b1, 1'b0);
    chk("ebk_halted", {63'd0, halted}, 64'd1);
    chk("ebk_abort", {63'd0, halt_abort}, 64'd0);
    chk("ebk_code", halt_code, 64'h2A);
    chk("ebk_pc", pc, 64'h8000_0104);
    chk("ebk_retired", retired, 64'd4);
    rd2(5'd10, "ebk_a0_kept", 64'h2A);

    // Commits while halted change nothing
    commit(1'b1, 5'd6, 64'h77, 1'b1, 64'h1000, 1'b0, 1'b0);
    commit(1'b1, 5'd6, 64'h77, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("hlt_pc", pc, 64'h8000_0104);
    chk("hlt_retired", retired, 64'd4);
    chk("hlt_abort", {63'd0, halt_abort}, 64'd0);
    chk("hlt_code", halt_code, 64'h2A);
    chk("hlt_halted", {63'd0, halted}, 64'd1);
    rd1(5'd6, "hlt_x6", 64'd0);

    // Reset while halted, with a commit presented
    rst = 1'b0;
    commit(1'b1, 5'd7, 64'h99, 1'b0, 64'd0, 1'b0, 1'b0);
    rst = 1'b1;
    chk("rh_pc", pc, 64'h8000_0000);
    chk("rh_retired", retired, 64'd0);
    chk("rh_halted", {63'd0, halted}, 64'd0);
    chk("rh_code", halt_code, 64'd0);
    rd1(5'd5, "rh_x5", 64'd0);
    rd2(5'd10, "rh_a0", 64'd0);

    // Abort at 0x8000_0008 with both causes set
    commit(1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    commit(1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("ab_pre_pc", pc, 64'h8000_0008);
    commit(1'b1, 5'd7, 64'h33, 1'b1, 64'h4000, 1'b1, 1'b1);
    chk("ab_halted", {63'd0, halted}, 64'd1);
    chk("ab_abort", {63'd0, halt_abort}, 64'd1);
    chk("ab_code", halt_code, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ab_pc", pc, 64'h8000_0008);
    chk("ab_retired", retired, 64'd2);
    rd1(5'd7, "ab_x7", 64'd0);

    // Leave HALT through reset, then reset concurrent with a RUN commit
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("ra_halted", {63'd0, halted}, 64'd0);
    chk("ra_abort", {63'd0, halt_abort}, 64'd0);
    rst = 1'b0;
    commit(1'b1, 5'd5, 64'h9, 1'b1, 64'h1234, 1'b0, 1'b0);
    rst = 1'b1;
    chk("rc_pc", pc, 64'h8000_0000);
    chk("rc_retired", retired, 64'd0);
    rd1(5'd5, "rc_x5", 64'd0);

    // PC wrap
    commit(1'b0, 5'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    chk("wr_pre_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    commit(1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("wr_pc", pc, 64'd0);
    chk("wr_retired", retired, 64'd2);

    // Halt causes without commit_valid are ignored
    inst_ebreak  = 1'b1;
    invalid_inst = 1'b1;
    tick();
    idle();
    chk("nv_halted", {63'd0, halted}, 64'd0);
    chk("nv_pc", pc, 64'd0);
    chk("nv_retired", retired, 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
